// File: rtl/sa_skew_fifo_pkg.sv
// Shared array geometry for the systolic datapath: operand lane count,
// operand width and the packed row width derived from them.
package sa_skew_fifo_pkg;

    localparam int unsigned SA_LANES     = 16;
    localparam int unsigned SA_DATA_BITS = 8;
    localparam int unsigned SA_DEPTH     = 4;

    // Packed row width; lane i lives at [i*data_bits +: data_bits].
    function automatic int unsigned sa_row_bits(input int unsigned lanes,
                                                input int unsigned data_bits);
        return lanes * data_bits;
    endfunction

endpackage

// File: rtl/sa_skew_fifo_if.sv
// Row/handshake bundle between the operand producer and the skew FIFO.
interface sa_skew_fifo_if
    import sa_skew_fifo_pkg::*;
#(
    parameter int unsigned LANES     = SA_LANES,
    parameter int unsigned DATA_BITS = SA_DATA_BITS,
    parameter int unsigned DEPTH     = SA_DEPTH
);

    localparam int unsigned ROW_BITS = sa_row_bits(LANES, DATA_BITS);
    localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);

    logic                flush;
    logic                skew_en;
    logic                push;
    logic [ROW_BITS-1:0] din;
    logic                full;
    logic                pop;
    logic [ROW_BITS-1:0] dout;
    logic [LANES-1:0]    dout_valid;
    logic                empty;
    logic [CNT_BITS-1:0] count;
    logic                busy;
    logic                overflow;

    modport master (
        output flush, skew_en, push, din, pop,
        input  full, dout, dout_valid, empty, count, busy, overflow
    );

    modport slave (
        input  flush, skew_en, push, din, pop,
        output full, dout, dout_valid, empty, count, busy, overflow
    );

endinterface

// File: rtl/sa_skew_fifo_lane_delay.sv
// Per-lane delay line: a DELAY-deep enable-gated shift chain carrying data
// plus a valid bit, tapped either at stage 0 (aligned) or at the last stage.
module sa_lane_delay #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DELAY = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic             tap_long,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             busy
);

    logic [WIDTH-1:0] data_q [DELAY];
    logic [DELAY-1:0] valid_q;

    // Shift one step per enable; in aligned mode the stages past the tap are
    // fed zeros so no stale valid lingers to confuse busy or a later mode change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < DELAY; k++) data_q[k] <= '0;
            valid_q <= '0;
        end else if (clr) begin
            for (int unsigned k = 0; k < DELAY; k++) data_q[k] <= '0;
            valid_q <= '0;
        end else if (en) begin
            data_q[0]  <= din;
            valid_q[0] <= din_valid;
            for (int unsigned k = 1; k < DELAY; k++) begin
                data_q[k]  <= tap_long ? data_q[k-1]  : '0;
                valid_q[k] <= tap_long ? valid_q[k-1] : 1'b0;
            end
        end
    end

    assign dout       = tap_long ? data_q[DELAY-1]  : data_q[0];
    assign dout_valid = tap_long ? valid_q[DELAY-1] : valid_q[0];
    assign busy       = |valid_q;

endmodule

// File: rtl/sa_skew_fifo.sv
// Row FIFO feeding the matrix multiply unit. Rows are stored whole, then each
// popped row is released through per-lane delay lines so lane i trails lane 0
// by i pops, forming the diagonal wavefront the systolic array consumes.
module sa_skew_fifo
    import sa_skew_fifo_pkg::*;
#(
    parameter int unsigned LANES     = SA_LANES,
    parameter int unsigned DATA_BITS = SA_DATA_BITS,
    parameter int unsigned DEPTH     = SA_DEPTH
) (
    input  logic           clk,
    input  logic           reset_n,
    sa_skew_fifo_if.slave  bus
);

    localparam int unsigned ROW_BITS = sa_row_bits(LANES, DATA_BITS);
    localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);
    localparam int unsigned PTR_BITS = $clog2(DEPTH);

    logic [ROW_BITS-1:0] mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [CNT_BITS-1:0] count_q;
    logic                overflow_q;

    logic                full;
    logic                empty;
    logic                push_ok;
    logic                pop_ok;
    logic [ROW_BITS-1:0] head_row;
    logic [ROW_BITS-1:0] dout_w;
    logic [LANES-1:0]    dout_valid_w;
    logic [LANES-1:0]    lane_busy;

    assign full  = (count_q == CNT_BITS'(DEPTH));
    assign empty = (count_q == '0);

    // A push into a full FIFO still lands when a pop frees the head slot in the
    // same edge; the head is read before the write replaces it.
    assign push_ok  = bus.push && (!full || bus.pop);
    assign pop_ok   = bus.pop && !empty;
    assign head_row = pop_ok ? mem[rd_ptr] : '0;

    // Row storage; contents are don't-care once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (push_ok && !bus.flush) mem[wr_ptr] <= bus.din;
    end

    // Pointers, occupancy and the sticky overflow flag; flush outranks push/pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= (wr_ptr == PTR_BITS'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= (rd_ptr == PTR_BITS'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (bus.push && full && !bus.pop) overflow_q <= 1'b1;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sa_lane_delay #(
            .WIDTH (DATA_BITS),
            .DELAY (i + 1)
        ) u_delay (
            .clk        (clk),
            .reset_n    (reset_n),
            .clr        (bus.flush),
            .en         (bus.pop),
            .tap_long   (bus.skew_en),
            .din        (head_row[i*DATA_BITS +: DATA_BITS]),
            .din_valid  (pop_ok),
            .dout       (dout_w[i*DATA_BITS +: DATA_BITS]),
            .dout_valid (dout_valid_w[i]),
            .busy       (lane_busy[i])
        );
    end

    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.dout       = dout_w;
    assign bus.dout_valid = dout_valid_w;
    assign bus.busy       = |lane_busy;

endmodule

// File: tb/tb_sa_skew_fifo.sv
// Directed bench for sa_skew_fifo with LANES=4, DATA_BITS=8, DEPTH=3.
module tb_sa_skew_fifo;

    localparam int unsigned LANES     = 4;
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned DEPTH     = 3;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    logic skew_q;

    sa_skew_fifo_if #(.LANES(LANES), .DATA_BITS(DATA_BITS), .DEPTH(DEPTH)) bus ();

    sa_skew_fifo #(
        .LANES     (LANES),
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // skew_en must not move while rows are still in flight
    initial skew_q = 1'b1;
    always @(negedge clk) begin
        assert (!(bus.busy && (bus.skew_en !== skew_q)))
            else $error("skew_en changed while busy");
        skew_q <= bus.skew_en;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_head  [5];
    logic [7:0] exp_drain [3];

    initial begin
        checks = 0;
        errors = 0;
        exp_head  = '{8'h11, 8'h22, 8'h33, 8'h55, 8'h66};
        exp_drain = '{8'h77, 8'h88, 8'h99};

        reset_n     = 1'b0;
        bus.flush   = 1'b0;
        bus.skew_en = 1'b1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.din     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_full",     64'(bus.full),       64'd0);
        check_eq("rst_empty",    64'(bus.empty),      64'd1);
        check_eq("rst_count",    64'(bus.count),      64'd0);
        check_eq("rst_busy",     64'(bus.busy),       64'd0);
        check_eq("rst_overflow", 64'(bus.overflow),   64'd0);
        check_eq("rst_dout",     64'(bus.dout),       64'd0);
        check_eq("rst_valid",    64'(bus.dout_valid), 64'd0);
        reset_n = 1'b1;

        // Skewed release of one row
        bus.din  = 32'h04030201;
        bus.push = 1'b1;
        tick();
        bus.push = 1'b0;
        check_eq("skew_count", 64'(bus.count), 64'd1);
        bus.pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("skew_valid", 64'(bus.dout_valid), 64'(4'b0001 << i));
            check_eq("skew_dout",  64'(bus.dout),       64'(32'(i + 1) << (8 * i)));
        end
        tick();
        bus.pop = 1'b0;
        check_eq("skew_busy_end",  64'(bus.busy),       64'd0);
        check_eq("skew_valid_end", 64'(bus.dout_valid), 64'd0);

        // Bypass: all lanes aligned after one pop
        bus.skew_en = 1'b0;
        bus.din     = 32'hAABBCCDD;
        bus.push    = 1'b1;
        tick();
        bus.push = 1'b0;
        bus.pop  = 1'b1;
        tick();
        check_eq("byp_dout",  64'(bus.dout),       64'h0000_0000_AABB_CCDD);
        check_eq("byp_valid", 64'(bus.dout_valid), 64'hF);
        tick();
        bus.pop = 1'b0;
        check_eq("byp_busy_end", 64'(bus.busy), 64'd0);
        bus.skew_en = 1'b1;

        // Fill past capacity: fourth row is dropped
        bus.push = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.din = 32'h11111111 * 32'(i + 1);
            tick();
            if (i == 2) check_eq("fill_ovf_early", 64'(bus.overflow), 64'd0);
        end
        check_eq("fill_count", 64'(bus.count),    64'd3);
        check_eq("fill_full",  64'(bus.full),     64'd1);
        check_eq("fill_ovf",   64'(bus.overflow), 64'd1);

        // Push+pop while full, crossing the pointer wrap
        bus.pop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.din = 32'h11111111 * 32'(i + 5);
            tick();
            check_eq("wrap_head",  64'(bus.dout[7:0]),     64'(exp_head[i]));
            check_eq("wrap_valid", 64'(bus.dout_valid[0]), 64'd1);
            check_eq("wrap_count", 64'(bus.count),         64'd3);
        end
        bus.push = 1'b0;
        check_eq("wrap_ovf_sticky", 64'(bus.overflow), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("drain_head", 64'(bus.dout[7:0]), 64'(exp_drain[i]));
        end
        check_eq("drain_count", 64'(bus.count), 64'd0);
        check_eq("drain_empty", 64'(bus.empty), 64'd1);
        repeat (3) tick();
        check_eq("drain_lane3", 64'(bus.dout[31:24]), 64'h99);
        check_eq("drain_valid", 64'(bus.dout_valid),  64'b1000);
        tick();
        bus.pop = 1'b0;
        check_eq("drain_busy", 64'(bus.busy), 64'd0);

        // Stall holds the pipe; then flush clears everything
        bus.din  = 32'hA1B2C3D4;
        bus.push = 1'b1;
        tick();
        bus.push = 1'b0;
        bus.pop  = 1'b1;
        tick();
        bus.pop = 1'b0;
        check_eq("stall_dout0",  64'(bus.dout),       64'h0000_0000_0000_00D4);
        check_eq("stall_valid0", 64'(bus.dout_valid), 64'b0001);
        bus.din = 32'h5A5A5A5A;
        for (int i = 0; i < 5; i++) begin
            bus.push = (i == 0);
            tick();
            check_eq("stall_dout",  64'(bus.dout),       64'h0000_0000_0000_00D4);
            check_eq("stall_valid", 64'(bus.dout_valid), 64'b0001);
        end
        bus.push = 1'b0;
        check_eq("stall_count", 64'(bus.count),    64'd1);
        check_eq("stall_ovf",   64'(bus.overflow), 64'd1);
        bus.flush = 1'b1;
        bus.push  = 1'b1;
        bus.pop   = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
        check_eq("flush_count", 64'(bus.count),      64'd0);
        check_eq("flush_empty", 64'(bus.empty),      64'd1);
        check_eq("flush_busy",  64'(bus.busy),       64'd0);
        check_eq("flush_ovf",   64'(bus.overflow),   64'd0);
        check_eq("flush_valid", 64'(bus.dout_valid), 64'd0);
        check_eq("flush_dout",  64'(bus.dout),       64'd0);

        // Push and pop together while empty: bubble now, row on the next pop
        bus.din  = 32'hCAFEBABE;
        bus.push = 1'b1;
        bus.pop  = 1'b1;
        tick();
        bus.push = 1'b0;
        check_eq("epp_bubble", 64'(bus.dout_valid[0]), 64'd0);
        check_eq("epp_count",  64'(bus.count),         64'd1);
        tick();
        bus.pop = 1'b0;
        check_eq("epp_head",   64'(bus.dout[7:0]),     64'hBE);
        check_eq("epp_valid",  64'(bus.dout_valid[0]), 64'd1);
        check_eq("epp_count2", 64'(bus.count),         64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
